// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller.
// Feeds one 4-bit slice of each operand per clock to an external 4-bit
// ripple-carry adder, chains the carry between slices and assembles the
// sum nibbles into a full-width result with a final carry-out.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [3:0]       adder_a,
  output logic [3:0]       adder_b,
  output logic             adder_cin,
  input  logic [3:0]       adder_sum,
  input  logic             adder_cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath update; busy/done are decoded from the next
  // state so that they come straight out of flops.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = op_b;
          carry_d  = cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = adder_sum;
        carry_d                = adder_cout;
        if (idx_q == IDX_LAST) begin
          // Hold idx on the last slice so it never wraps mid-operation.
          cout_d  = adder_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // All controller state, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Adder drive: current slice and chained carry in RUN, quiet otherwise.
  always_comb begin
    adder_a   = 4'd0;
    adder_b   = 4'd0;
    adder_cin = 1'b0;
    if (state_q == RUN) begin
      adder_a   = a_q[4*idx_q +: 4];
      adder_b   = b_q[4*idx_q +: 4];
      adder_cin = carry_q;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Testbench for nibble_serial_add_ctrl (WIDTH=16) with a behavioural
// 4-bit adder wired to the adder_* ports.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic [3:0]       adder_a;
  logic [3:0]       adder_b;
  logic             adder_cin;
  logic [3:0]       adder_sum;
  logic             adder_cout;

  int n_cmp  = 0;
  int n_fail = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .adder_a   (adder_a),
    .adder_b   (adder_b),
    .adder_cin (adder_cin),
    .adder_sum (adder_sum),
    .adder_cout(adder_cout)
  );

  // Behavioural external 4-bit adder.
  assign {adder_cout, adder_sum} = 5'(adder_a) + 5'(adder_b) + 5'(adder_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] res;
    logic        co;
    logic [3:0]  cseq;   // bit k = expected adder_cin during slice k
  } vec_t;

  vec_t vecs[5];

  // Starts one operation from the current negedge (IDLE assumed) and checks
  // timing, adder drive, carry chain and result. With disturb set, start is
  // re-asserted with other operands through RUN and DONE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] er, input logic eco,
                        input logic [3:0] ecs, input bit disturb);
    int          done_cnt;
    int          done_cyc;
    int          busy_cnt;
    logic [3:0]  cseq;
    bit          drv_ok;
    logic [15:0] res_at_done;
    logic        co_at_done;
    done_cnt    = 0;
    done_cyc    = 0;
    busy_cnt    = 0;
    cseq        = 4'd0;
    drv_ok      = 1'b1;
    res_at_done = 16'd0;
    co_at_done  = 1'b0;
    start = 1'b1; op_a = a; op_b = b; cin = c;
    @(posedge clk);
    #1;
    start = 1'b0; op_a = ~a; op_b = a ^ b; cin = ~c;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc    = cyc;
        res_at_done = result;
        co_at_done  = cout;
      end
      if (cyc <= 4) begin
        cseq[cyc-1] = adder_cin;
        if (adder_a !== a[4*(cyc-1) +: 4] || adder_b !== b[4*(cyc-1) +: 4]) drv_ok = 1'b0;
      end else if (adder_a !== 4'd0 || adder_b !== 4'd0 || adder_cin !== 1'b0) begin
        drv_ok = 1'b0;
      end
      if (disturb) begin
        if (cyc >= 2 && cyc <= 5) begin
          start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b1;
        end else if (cyc == 6) begin
          start = 1'b0;
        end
      end
    end
    chk({tag, ".result"},      32'(result),      32'(er));
    chk({tag, ".cout"},        32'(cout),        32'(eco));
    chk({tag, ".result_done"}, 32'(res_at_done), 32'(er));
    chk({tag, ".cout_done"},   32'(co_at_done),  32'(eco));
    chk({tag, ".done_pulses"}, 32'(done_cnt),    32'd1);
    chk({tag, ".done_cycle"},  32'(done_cyc),    32'd5);
    chk({tag, ".busy_cycles"}, 32'(busy_cnt),    32'd5);
    chk({tag, ".cin_chain"},   32'(cseq),        32'(ecs));
    chk({tag, ".adder_drive"}, 32'(drv_ok),      32'd1);
  endtask

  initial begin
    vecs[0] = '{"v1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'b0000};
    vecs[1] = '{"vFFFF_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1110};
    vecs[2] = '{"v00F0_0010", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 4'b0100};
    vecs[3] = '{"v0000_cin1", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'b0001};
    vecs[4] = '{"v8000_cin1", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 4'b0001};

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.busy",      32'(busy),      32'd0);
    chk("reset.done",      32'(done),      32'd0);
    chk("reset.result",    32'(result),    32'd0);
    chk("reset.cout",      32'(cout),      32'd0);
    chk("reset.adder_a",   32'(adder_a),   32'd0);
    chk("reset.adder_b",   32'(adder_b),   32'd0);
    chk("reset.adder_cin", 32'(adder_cin), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive entries are back-to-back: each start is raised in the
    // first IDLE cycle after the previous DONE.
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].c,
             vecs[i].res, vecs[i].co, vecs[i].cseq, 1'b0);
    end

    // start held high through RUN and DONE with other operands: ignored.
    run_op("busy_start", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 4'b0000, 1'b1);

    // Asynchronous reset in the second RUN cycle.
    start = 1'b1; op_a = 16'h1234; op_b = 16'h1111; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst.pre_busy",   32'(busy),   32'd1);
    chk("midrst.pre_result", 32'(result), 32'h0005);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.busy",      32'(busy),      32'd0);
    chk("midrst.done",      32'(done),      32'd0);
    chk("midrst.result",    32'(result),    32'd0);
    chk("midrst.cout",      32'(cout),      32'd0);
    chk("midrst.adder_a",   32'(adder_a),   32'd0);
    chk("midrst.adder_b",   32'(adder_b),   32'd0);
    chk("midrst.adder_cin", 32'(adder_cin), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 4'b1110, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
